// File: rtl/cpu_status_pkg.sv
// Shared types and constants for the processor status (P) register.
// Flag bit positions follow the classic {N,V,1,B,D,I,Z,C} layout.
package cpu_status_pkg;

    typedef enum logic [2:0] {
        FOP_NONE,
        FOP_SEC,
        FOP_CLC,
        FOP_SEI,
        FOP_CLI,
        FOP_SED,
        FOP_CLD,
        FOP_CLV
    } flag_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUSH,
        ST_PULL
    } state_e;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h24;

    // The register never stores B; U always reads as one.
    function automatic logic [7:0] fix_p(input logic [7:0] p);
        logic [7:0] r;
        r      = p;
        r[P_U] = 1'b1;
        r[P_B] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/status_register_branch_eval.sv
// Branch condition evaluator: compares one selected flag of P
// against the wanted value, purely combinational.
module branch_eval
    import cpu_status_pkg::*;
(
    input  logic [7:0] p,
    input  logic [2:0] cond,
    output logic       taken
);

    logic flag;

    always_comb begin
        flag = 1'b0;
        unique case (cond[2:1])
            2'b00: flag = p[P_N];
            2'b01: flag = p[P_V];
            2'b10: flag = p[P_C];
            2'b11: flag = p[P_Z];
            default: flag = 1'b0;
        endcase
    end

    assign taken = (flag == cond[0]);

endmodule

// File: rtl/status_register.sv
// Processor status register with flag updates, flag ops,
// stack push/pull handshakes and branch evaluation.
module status_register
    import cpu_status_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_n_in,
    input  logic       flag_z_in,
    input  logic       flag_c_in,
    input  logic       flag_v_in,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] flag_op,
    input  logic       push_req,
    input  logic       push_brk,
    input  logic       push_sei,
    input  logic       pull_req,
    output logic       stk_wr_valid,
    output logic [7:0] stk_wr_data,
    input  logic       stk_wr_ready,
    output logic       stk_rd_req,
    input  logic       stk_rd_valid,
    input  logic [7:0] stk_rd_data,
    input  logic [2:0] branch_cond,
    output logic       branch_taken,
    output logic [7:0] p_out,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [7:0] p_q, p_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       sei_q, sei_d;
    flag_op_e   op;

    assign op = flag_op_e'(flag_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            p_q       <= P_RESET;
            wr_data_q <= 8'h00;
            sei_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            wr_data_q <= wr_data_d;
            sei_q     <= sei_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (push_req) begin
                    state_d = ST_PUSH;
                end else if (pull_req) begin
                    state_d = ST_PULL;
                end
            end
            ST_PUSH: if (stk_wr_ready) state_d = ST_IDLE;
            ST_PULL: if (stk_rd_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p_d       = p_q;
        wr_data_d = wr_data_q;
        sei_d     = sei_q;
        unique case (state_q)
            ST_IDLE: begin
                if (upd_nz) begin
                    p_d[P_N] = flag_n_in;
                    p_d[P_Z] = flag_z_in;
                end
                if (upd_c) p_d[P_C] = flag_c_in;
                if (upd_v) p_d[P_V] = flag_v_in;
                // Explicit flag ops win over ALU results on the same bit.
                unique case (op)
                    FOP_SEC:  p_d[P_C] = 1'b1;
                    FOP_CLC:  p_d[P_C] = 1'b0;
                    FOP_SEI:  p_d[P_I] = 1'b1;
                    FOP_CLI:  p_d[P_I] = 1'b0;
                    FOP_SED:  p_d[P_D] = 1'b1;
                    FOP_CLD:  p_d[P_D] = 1'b0;
                    FOP_CLV:  p_d[P_V] = 1'b0;
                    default:  p_d = p_d;
                endcase
                if (push_req) begin
                    wr_data_d = {p_q[7:6], 1'b1, push_brk, p_q[3:0]};
                    sei_d     = push_sei;
                end
            end
            ST_PUSH: begin
                if (stk_wr_ready && sei_q) p_d[P_I] = 1'b1;
            end
            ST_PULL: begin
                if (stk_rd_valid) p_d = stk_rd_data;
            end
            default: p_d = p_q;
        endcase
        p_d = fix_p(p_d);
    end

    always_comb begin
        stk_wr_valid = 1'b0;
        stk_rd_req   = 1'b0;
        busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_PUSH: stk_wr_valid = 1'b1;
            ST_PULL: stk_rd_req   = 1'b1;
            default: ;
        endcase
    end

    assign stk_wr_data = wr_data_q;
    assign p_out       = p_q;

    branch_eval u_branch (
        .p     (p_q),
        .cond  (branch_cond),
        .taken (branch_taken)
    );

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed scenarios plus a random
// run against a flag-level reference model.
module tb_status_register;
    import cpu_status_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_n_in, flag_z_in, flag_c_in, flag_v_in;
    logic       upd_nz, upd_c, upd_v;
    logic [2:0] flag_op;
    logic       push_req, push_brk, push_sei, pull_req;
    logic       stk_wr_valid, stk_wr_ready;
    logic [7:0] stk_wr_data;
    logic       stk_rd_req, stk_rd_valid;
    logic [7:0] stk_rd_data;
    logic [2:0] branch_cond;
    logic       branch_taken;
    logic [7:0] p_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    status_register dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flag_n_in    (flag_n_in),
        .flag_z_in    (flag_z_in),
        .flag_c_in    (flag_c_in),
        .flag_v_in    (flag_v_in),
        .upd_nz       (upd_nz),
        .upd_c        (upd_c),
        .upd_v        (upd_v),
        .flag_op      (flag_op),
        .push_req     (push_req),
        .push_brk     (push_brk),
        .push_sei     (push_sei),
        .pull_req     (pull_req),
        .stk_wr_valid (stk_wr_valid),
        .stk_wr_data  (stk_wr_data),
        .stk_wr_ready (stk_wr_ready),
        .stk_rd_req   (stk_rd_req),
        .stk_rd_valid (stk_rd_valid),
        .stk_rd_data  (stk_rd_data),
        .branch_cond  (branch_cond),
        .branch_taken (branch_taken),
        .p_out        (p_out),
        .busy         (busy)
    );

    // Reference: P seen as six independent flags plus fixed bits.
    function automatic logic [7:0] m_idle(
        input logic [7:0] p,
        input logic unz, input logic n, input logic z,
        input logic uc, input logic c,
        input logic uv, input logic v,
        input logic [2:0] op
    );
        logic fn, fv, fd, fi, fz, fc;
        fn = p[7]; fv = p[6]; fd = p[3];
        fi = p[2]; fz = p[1]; fc = p[0];
        if (unz) begin fn = n; fz = z; end
        if (uc) fc = c;
        if (uv) fv = v;
        case (op)
            3'd1: fc = 1'b1;
            3'd2: fc = 1'b0;
            3'd3: fi = 1'b1;
            3'd4: fi = 1'b0;
            3'd5: fd = 1'b1;
            3'd6: fd = 1'b0;
            3'd7: fv = 1'b0;
            default: ;
        endcase
        return {fn, fv, 2'b10, fd, fi, fz, fc};
    endfunction

    function automatic logic m_branch(input logic [7:0] p, input logic [2:0] cond);
        int idx;
        case (cond[2:1])
            2'd0: idx = 7;
            2'd1: idx = 6;
            2'd2: idx = 0;
            default: idx = 1;
        endcase
        return p[idx] == cond[0];
    endfunction

    task automatic quiet();
        flag_n_in = 0; flag_z_in = 0; flag_c_in = 0; flag_v_in = 0;
        upd_nz = 0; upd_c = 0; upd_v = 0;
        flag_op = FOP_NONE;
        push_req = 0; push_brk = 0; push_sei = 0; pull_req = 0;
        stk_wr_ready = 0; stk_rd_valid = 0; stk_rd_data = 8'h00;
        branch_cond = 3'b000;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        #3;
        checks++;
        if (p_out !== 8'h24 || busy !== 1'b0 || stk_wr_valid !== 1'b0 ||
            stk_rd_req !== 1'b0 || stk_wr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: p=%h busy=%b wv=%b rr=%b wd=%h want 24 0 0 0 00",
                     p_out, busy, stk_wr_valid, stk_rd_req, stk_wr_data);
        end
        edge1();
        rst_n = 1'b1;
        upd_nz = 1; flag_n_in = 1; flag_z_in = 0;
        edge1();
        quiet();
        checks++;
        if (p_out !== 8'hA4) begin
            errors++;
            $display("FAIL upd_nz_after_reset: got %h want a4", p_out);
        end
    endtask

    task automatic test_sec_override();
        do_reset();
        upd_c = 1; flag_c_in = 0; flag_op = FOP_SEC;
        edge1();
        quiet();
        checks++;
        if (p_out !== 8'h25) begin
            errors++;
            $display("FAIL sec_override: got %h want 25", p_out);
        end
    endtask

    task automatic test_push();
        do_reset();
        upd_nz = 1; flag_n_in = 1; flag_z_in = 0;
        upd_c = 1; flag_c_in = 1;
        upd_v = 1; flag_v_in = 1;
        flag_op = FOP_CLI;
        edge1();
        quiet();
        checks++;
        if (p_out !== 8'hE1) begin
            errors++;
            $display("FAIL push_setup: got %h want e1", p_out);
        end
        push_req = 1; push_brk = 1; push_sei = 1;
        edge1();
        quiet();
        for (int k = 0; k < 4; k++) begin
            upd_c = 1; flag_c_in = 0; flag_op = FOP_CLV;
            stk_wr_ready = (k == 3);
            #1;
            checks++;
            if (stk_wr_valid !== 1'b1 || stk_wr_data !== 8'hF1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL push_hold[%0d]: wv=%b wd=%h busy=%b want 1 f1 1",
                         k, stk_wr_valid, stk_wr_data, busy);
            end
            edge1();
        end
        quiet();
        checks++;
        if (busy !== 1'b0 || stk_wr_valid !== 1'b0 || p_out !== 8'hE5) begin
            errors++;
            $display("FAIL push_done: busy=%b wv=%b p=%h want 0 0 e5",
                     busy, stk_wr_valid, p_out);
        end
    endtask

    task automatic test_pull();
        quiet();
        pull_req = 1;
        edge1();
        quiet();
        checks++;
        if (stk_rd_req !== 1'b1 || busy !== 1'b1 || stk_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL pull_start: rr=%b busy=%b wv=%b want 1 1 0",
                     stk_rd_req, busy, stk_wr_valid);
        end
        edge1();
        checks++;
        if (stk_rd_req !== 1'b1 || p_out !== 8'hE5) begin
            errors++;
            $display("FAIL pull_wait: rr=%b p=%h want 1 e5", stk_rd_req, p_out);
        end
        stk_rd_valid = 1; stk_rd_data = 8'hDF;
        edge1();
        quiet();
        checks++;
        if (p_out !== 8'hEF || stk_rd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pull_done: p=%h rr=%b busy=%b want ef 0 0",
                     p_out, stk_rd_req, busy);
        end
    endtask

    task automatic test_priority();
        do_reset();
        push_req = 1; pull_req = 1;
        edge1();
        quiet();
        checks++;
        if (stk_wr_valid !== 1'b1 || stk_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL priority_push: wv=%b rr=%b want 1 0", stk_wr_valid, stk_rd_req);
        end
        stk_wr_ready = 1;
        edge1();
        quiet();
        checks++;
        if (busy !== 1'b0 || stk_rd_req !== 1'b0 || p_out !== 8'h24) begin
            errors++;
            $display("FAIL priority_done: busy=%b rr=%b p=%h want 0 0 24",
                     busy, stk_rd_req, p_out);
        end
    endtask

    task automatic test_branch();
        do_reset();
        upd_c = 1; flag_c_in = 1;
        edge1();
        quiet();
        branch_cond = 3'b101;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL branch_c1: got %b want 1", branch_taken);
        end
        branch_cond = 3'b100;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_c0: got %b want 0", branch_taken);
        end
        branch_cond = 3'b000;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL branch_n0: got %b want 1", branch_taken);
        end
        branch_cond = 3'b111;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_z1: got %b want 0", branch_taken);
        end
    endtask

    task automatic test_reset_mid_pull();
        do_reset();
        upd_nz = 1; flag_n_in = 1;
        edge1();
        quiet();
        pull_req = 1;
        edge1();
        quiet();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (p_out !== 8'h24 || stk_rd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pull: p=%h rr=%b busy=%b want 24 0 0",
                     p_out, stk_rd_req, busy);
        end
        stk_rd_valid = 1; stk_rd_data = 8'hFF;
        edge1();
        quiet();
        rst_n = 1'b1;
        checks++;
        if (p_out !== 8'h24) begin
            errors++;
            $display("FAIL reset_no_load: got %h want 24", p_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_req = 1; stk_wr_ready = 1;
        edge1();
        push_req = 0;
        checks++;
        if (stk_wr_valid !== 1'b1 || stk_wr_data !== 8'h24) begin
            errors++;
            $display("FAIL b2b_push: wv=%b wd=%h want 1 24", stk_wr_valid, stk_wr_data);
        end
        edge1();
        quiet();
        checks++;
        if (busy !== 1'b0 || p_out !== 8'h24) begin
            errors++;
            $display("FAIL b2b_push_done: busy=%b p=%h want 0 24", busy, p_out);
        end
        pull_req = 1; stk_rd_valid = 1; stk_rd_data = 8'h03;
        edge1();
        pull_req = 0;
        checks++;
        if (stk_rd_req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pull: rr=%b want 1", stk_rd_req);
        end
        edge1();
        quiet();
        checks++;
        if (p_out !== 8'h23 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pull_done: p=%h busy=%b want 23 0", p_out, busy);
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] mp, mdata;
        logic       msei;
        int         mmode;
        do_reset();
        mp = 8'h24; mdata = 8'h00; msei = 0; mmode = 0;
        for (int i = 0; i < n; i++) begin
            flag_n_in = 1'($urandom); flag_z_in = 1'($urandom);
            flag_c_in = 1'($urandom); flag_v_in = 1'($urandom);
            upd_nz = 1'($urandom); upd_c = 1'($urandom); upd_v = 1'($urandom);
            flag_op = 3'($urandom);
            push_req = ($urandom_range(0, 7) == 0);
            pull_req = ($urandom_range(0, 5) == 0);
            push_brk = 1'($urandom); push_sei = 1'($urandom);
            stk_wr_ready = 1'($urandom);
            stk_rd_valid = 1'($urandom);
            stk_rd_data = 8'($urandom);
            branch_cond = 3'($urandom);
            #1;
            checks++;
            if (branch_taken !== m_branch(mp, branch_cond)) begin
                errors++;
                $display("FAIL rnd_branch[%0d]: got %b want %b cond=%b p=%h",
                         i, branch_taken, m_branch(mp, branch_cond), branch_cond, mp);
            end
            if (mmode == 0) begin
                if (push_req) begin
                    mdata = {mp[7:6], 1'b1, push_brk, mp[3:0]};
                    msei = push_sei;
                    mmode = 1;
                end else if (pull_req) begin
                    mmode = 2;
                end
                mp = m_idle(mp, upd_nz, flag_n_in, flag_z_in, upd_c, flag_c_in,
                            upd_v, flag_v_in, flag_op);
            end else if (mmode == 1) begin
                if (stk_wr_ready) begin
                    if (msei) mp[2] = 1'b1;
                    mmode = 0;
                end
            end else begin
                if (stk_rd_valid) begin
                    mp = {stk_rd_data[7:6], 2'b10, stk_rd_data[3:0]};
                    mmode = 0;
                end
            end
            edge1();
            checks++;
            if (p_out !== mp || busy !== (mmode != 0) ||
                stk_wr_valid !== (mmode == 1) || stk_rd_req !== (mmode == 2) ||
                (mmode == 1 && stk_wr_data !== mdata)) begin
                errors++;
                $display("FAIL rnd_state[%0d]: p=%h busy=%b wv=%b rr=%b wd=%h want p=%h mode=%0d wd=%h",
                         i, p_out, busy, stk_wr_valid, stk_rd_req, stk_wr_data,
                         mp, mmode, mdata);
            end
        end
        quiet();
    endtask

    initial begin
        quiet();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_sec_override();
        test_push();
        test_pull();
        test_priority();
        test_branch();
        test_reset_mid_pull();
        test_back_to_back();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
